sd3_frame_tx: RTL
=================

Name: sd3_frame_tx

Overview:
- Serial frame transmitter that drives the 1-bit data input of the 6-bit frame sequence detector.
- Accepts frame words over a valid/ready interface, or generates them itself. Shifts them out MSB-first, one bit per clk, back-to-back.
- Keeps a free-running slot counter aligned to the detector's 1..6 frame counter. The bench scoreboards the detector against this block's expect_match.

Parameters:
- FRAME_W, 6, bits per frame (slot counter range 1..FRAME_W).
- PATTERN, 6'b011100, frame value the detector reports as a match; also the auto-mode frame.
- FILL, 6'b111111, frame sent on underrun; must differ from PATTERN.
- ERR_MASK, 6'b000001, XOR mask applied to a frame when err_inject is sampled at load.
- CNT_W, 16, width of frame_cnt.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: in_frame valid.
- in_ready, out, 1: block can accept in_frame this cycle.
- in_frame, in, FRAME_W: frame word, bit FRAME_W-1 sent first.
- mode, in, 1: 0 = stream from input, 1 = auto-generate PATTERN.
- err_inject, in, 1: corrupt the next loaded frame with ERR_MASK.
- data, out, 1: serial bit to the detector.
- slot, out, 4: current bit slot, 0 in reset, then 1..FRAME_W.
- frame_start, out, 1: high while slot==1.
- frame_last, out, 1: high while slot==FRAME_W.
- expect_match, out, 1: frame now on data equals PATTERN; constant for the whole frame.
- underrun, out, 1: one-cycle pulse, FILL loaded.
- frame_cnt, out, CNT_W: frames loaded since reset, wraps.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - slot=0, data=1, frame_start=0, frame_last=0, expect_match=0, underrun=0, frame_cnt=0.
  - Holding buffer emptied; shift register cleared; any in-flight frame is dropped.
- Slot counter, every clk: slot <= (slot==0 || slot==FRAME_W) ? 1 : slot+1. It never stalls, so slot tracks the detector's frame counter from reset.
- Boundary edge = a clk edge where slot==0 or slot==FRAME_W. At each boundary edge the shift register loads the next frame F:
  - mode=1: F = PATTERN.
  - mode=0 with buffer full: F = buffer word, and the buffer empties.
  - mode=0 with buffer empty: F = FILL, and underrun pulses high for the following cycle.
  - If err_inject=1 at the boundary edge: F = F ^ ERR_MASK.
  - expect_match <= (F == PATTERN), after the mask is applied.
  - frame_cnt <= frame_cnt+1 on every load, including FILL frames.
- Serialization:
  - data is registered. At the edge where slot becomes s, data <= F[FRAME_W-s].
  - Net effect: data changes on the same edge as slot, with zero added latency.
- Holding buffer: one entry.
  - in_ready = (mode==0) && (!buf_full || boundary_load_from_buf). The bypass is combinational, so a full buffer can refill on the same edge it drains.
  - A word is accepted when in_valid && in_ready.
  - A word accepted on a boundary edge with the buffer empty goes to the buffer only (no buffer-to-shift bypass). That frame is an underrun; the word is sent in the next frame.
  - mode=1: in_ready=0 and any buffer content is retained untouched.
- Mode and err_inject are sampled only at boundary edges; a change mid-frame takes effect at the next frame.
- in_frame must be stable while in_valid && !in_ready; this is a source obligation, not checked here.

Test Plan:
- Reset release, mode=1, 3 frames -> slot 1..6 repeating; data = 0,1,1,1,0,0 per frame; expect_match=1; frame_cnt=3; underrun never asserts.
- mode=0, word 6'b011100 held valid before reset release -> first frame (no buffer) is FILL with underrun pulse, data=1 x6, expect_match=0; second frame sends 011100 with expect_match=1.
- mode=0, continuous source 6'b101010, 6'b011100, 6'b000000, one word per frame -> no underrun, frames back-to-back, expect_match = 0,1,0; in_ready drops after each fill and re-asserts on the boundary edge via bypass.
- mode=1, err_inject pulsed on the 2nd boundary edge -> 2nd frame is 011101 with expect_match=0; 1st and 3rd frames are 011100.
- Reset asserted at slot=3 of a frame with the buffer full -> all outputs return to reset values immediately; after release slot restarts at 1 and the buffered word is lost (FILL + underrun).
- Source stalls for 2 frames -> two FILL frames, two underrun pulses, frame_cnt still increments; slot alignment unaffected.

Source files
------------

// File: rtl/sd3_frame_tx.sv
// sd3_frame_tx: serial frame source for the 6-bit frame sequence detector.
// Takes frame words over valid/ready, or generates PATTERN in auto mode,
// and shifts them out MSB-first on data, one bit per clk, back-to-back.
// A free-running slot counter (0 in reset, then 1..FRAME_W) tracks the
// detector's frame counter so expect_match lines up with its verdict.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    handshake for in_frame (one-entry holding buffer)
//   in_frame             frame word, bit FRAME_W-1 sent first
//   mode                 0 = stream from input, 1 = auto-generate PATTERN
//   err_inject           XOR ERR_MASK into the frame loaded at this boundary
//   data                 registered serial bit to the detector
//   slot                 current bit slot
//   frame_start/last     slot==1 / slot==FRAME_W
//   expect_match         frame now on data equals PATTERN
//   underrun             one-cycle pulse when FILL was loaded
//   frame_cnt            frames loaded since reset (wraps)
module sd3_frame_tx #(
    parameter int                 FRAME_W  = 6,
    parameter logic [FRAME_W-1:0] PATTERN  = 6'b011100,
    parameter logic [FRAME_W-1:0] FILL     = 6'b111111,
    parameter logic [FRAME_W-1:0] ERR_MASK = 6'b000001,
    parameter int                 CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FRAME_W-1:0] in_frame,
    input  logic               mode,
    input  logic               err_inject,
    output logic               data,
    output logic [3:0]         slot,
    output logic               frame_start,
    output logic               frame_last,
    output logic               expect_match,
    output logic               underrun,
    output logic [CNT_W-1:0]   frame_cnt
);

    logic               boundary;
    logic               load_from_buf;
    logic               accept;
    logic               buf_full;
    logic [FRAME_W-1:0] buf_word;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] next_frame;
    logic [3:0]         slot_nxt;

    // A boundary edge is the one that moves slot to 1; the next frame loads there.
    assign boundary      = (slot == 4'd0) || (slot == 4'(FRAME_W));
    assign load_from_buf = boundary && !mode && buf_full;
    // Draining the buffer on this edge frees it for a new word on the same edge.
    assign in_ready      = !mode && (!buf_full || load_from_buf);
    assign accept        = in_valid && in_ready;
    assign slot_nxt      = boundary ? 4'd1 : slot + 4'd1;

    always_comb begin
        if (mode)
            next_frame = PATTERN;
        else if (buf_full)
            next_frame = buf_word;
        else
            next_frame = FILL;
        if (err_inject)
            next_frame = next_frame ^ ERR_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= 4'd0;
            data         <= 1'b1;
            frame_start  <= 1'b0;
            frame_last   <= 1'b0;
            expect_match <= 1'b0;
            underrun     <= 1'b0;
            frame_cnt    <= '0;
            shreg        <= '0;
            buf_full     <= 1'b0;
            buf_word     <= '0;
        end else begin
            slot        <= slot_nxt;
            frame_start <= (slot_nxt == 4'd1);
            frame_last  <= (slot_nxt == 4'(FRAME_W));
            underrun    <= boundary && !mode && !buf_full;

            if (boundary) begin
                // MSB goes straight to data; shreg holds the remaining bits.
                data         <= next_frame[FRAME_W-1];
                shreg        <= {next_frame[FRAME_W-2:0], 1'b0};
                expect_match <= (next_frame == PATTERN);
                frame_cnt    <= frame_cnt + 1'b1;
            end else begin
                data  <= shreg[FRAME_W-1];
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end

            // Accept has priority: a word taken on a draining edge refills the buffer.
            if (accept) begin
                buf_full <= 1'b1;
                buf_word <= in_frame;
            end else if (load_from_buf) begin
                buf_full <= 1'b0;
            end
        end
    end

endmodule
